// File: rtl/pwm_shadow_generator_pkg.sv
// Shared defaults and the write-decoder register map for the PWM shadow generator.
// Both are shared with the MCU bus decoder.
package pwm_shadow_generator_pkg;

  localparam int unsigned CNT_W_DEF       = 24;
  localparam int unsigned NCH_DEF         = 4;
  localparam int unsigned WDOG_W_DEF      = 26;
  localparam int unsigned WDOG_CYCLES_DEF = 5_000_000;  // 100 ms @ 50 MHz

  // Byte addresses used by the write decoder.
  // A commit follows the write to DUTY4_L.
  typedef enum logic [3:0] {
    PERIOD_H = 4'd0,  PERIOD_M = 4'd1,  PERIOD_L = 4'd2,
    DUTY1_H  = 4'd3,  DUTY1_M  = 4'd4,  DUTY1_L  = 4'd5,
    DUTY2_H  = 4'd6,  DUTY2_M  = 4'd7,  DUTY2_L  = 4'd8,
    DUTY3_H  = 4'd9,  DUTY3_M  = 4'd10, DUTY3_L  = 4'd11,
    DUTY4_H  = 4'd12, DUTY4_M  = 4'd13, DUTY4_L  = 4'd14
  } reg_addr_e;

endpackage

// File: rtl/pwm_shadow_generator_if.sv
// Configuration bus from the write decoder.
// It carries the timing words, the commit strobe and the load acknowledge.
interface pwm_shadow_generator_if
  import pwm_shadow_generator_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned NCH   = NCH_DEF
);
  logic [CNT_W-1:0]     period_in;
  logic [NCH*CNT_W-1:0] duty_in;
  logic                 cfg_commit;
  logic                 update_ack;

  modport master (output period_in, duty_in, cfg_commit, input update_ack);
  modport slave  (input period_in, duty_in, cfg_commit, output update_ack);
endinterface

// File: rtl/pwm_shadow_generator_cmp_channel.sv
// One PWM channel.
// It holds the active duty word, clamped to the period at load time, and a registered comparator output.
module pwm_cmp_channel
  import pwm_shadow_generator_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             pwm_clk,
  input  logic             reset,
  input  logic             load,
  input  logic             enable,
  input  logic [CNT_W-1:0] period_in,
  input  logic [CNT_W-1:0] duty_in,
  input  logic [CNT_W-1:0] cnt,
  output logic             pwm_out
);
  logic [CNT_W-1:0] duty_act;

  always_ff @(posedge pwm_clk) begin
    if (reset) begin
      duty_act <= '0;
      pwm_out  <= 1'b0;
    end else begin
      if (load) duty_act <= (duty_in > period_in) ? period_in : duty_in;
      pwm_out <= enable && (cnt < duty_act);
    end
  end
endmodule

// File: rtl/pwm_shadow_generator.sv
// Four-channel ESC PWM generator with shadowed timing words and boundary-synchronous swap.
// A link-loss watchdog forces the outputs low.
module pwm_shadow_generator
  import pwm_shadow_generator_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned NCH         = NCH_DEF,
  parameter int unsigned WDOG_W      = WDOG_W_DEF,
  parameter int unsigned WDOG_CYCLES = WDOG_CYCLES_DEF
) (
  input  logic                     pwm_clk,
  input  logic                     reset,
  pwm_shadow_generator_if.slave    cfg,
  output logic [NCH-1:0]           pwm_out,
  output logic                     period_tick,
  output logic                     failsafe
);
  localparam logic [WDOG_W-1:0] WD_LIMIT = WDOG_W'(WDOG_CYCLES);

  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  period_act;
  logic              pending;
  logic [WDOG_W-1:0] wd_cnt;
  logic              update_ack;
  logic              boundary;
  logic              load;
  logic              chan_en;

  // A zero period wraps every cycle, so an idle generator accepts a commit immediately.
  assign boundary = (period_act == '0) || (cnt == period_act - CNT_W'(1));
  assign load     = boundary && (pending || cfg.cfg_commit);
  assign chan_en  = !failsafe && (period_act != '0);

  assign cfg.update_ack = update_ack;

  always_ff @(posedge pwm_clk) begin
    if (reset) begin
      cnt         <= '0;
      period_act  <= '0;
      pending     <= 1'b0;
      wd_cnt      <= '0;
      period_tick <= 1'b0;
      failsafe    <= 1'b1;
      update_ack  <= 1'b0;
    end else begin
      period_tick <= boundary;
      cnt         <= boundary ? '0 : cnt + CNT_W'(1);
      update_ack  <= 1'b0;

      if (cfg.cfg_commit)          wd_cnt <= '0;
      else if (wd_cnt != WD_LIMIT) wd_cnt <= wd_cnt + WDOG_W'(1);

      if (wd_cnt == WD_LIMIT) failsafe <= 1'b1;
      if (cfg.cfg_commit)     pending  <= 1'b1;

      // A load is fresh evidence of a live link, so it overrides the expiry above.
      if (load) begin
        period_act <= cfg.period_in;
        pending    <= 1'b0;
        update_ack <= 1'b1;
        failsafe   <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    pwm_cmp_channel #(.CNT_W(CNT_W)) u_ch (
      .pwm_clk   (pwm_clk),
      .reset     (reset),
      .load      (load),
      .enable    (chan_en),
      .period_in (cfg.period_in),
      .duty_in   (cfg.duty_in[i*CNT_W +: CNT_W]),
      .cnt       (cnt),
      .pwm_out   (pwm_out[i])
    );
  end
endmodule

// File: tb/tb_pwm_shadow_generator.sv
// Directed and randomized checks of pwm_shadow_generator.
// Expected values come from an integer-level model of the period/shadow/watchdog rules.
module tb_pwm_shadow_generator;
  localparam int CNT_W = 24;
  localparam int NCH   = 4;
  localparam int WD    = 50;

  logic           pwm_clk = 1'b0;
  logic           reset;
  logic [NCH-1:0] pwm_out;
  logic           period_tick;
  logic           failsafe;

  pwm_shadow_generator_if #(.CNT_W(CNT_W), .NCH(NCH)) cfg_bus ();

  pwm_shadow_generator #(
    .CNT_W       (CNT_W),
    .NCH         (NCH),
    .WDOG_W      (26),
    .WDOG_CYCLES (WD)
  ) dut (
    .pwm_clk     (pwm_clk),
    .reset       (reset),
    .cfg         (cfg_bus),
    .pwm_out     (pwm_out),
    .period_tick (period_tick),
    .failsafe    (failsafe)
  );

  always #5 pwm_clk = ~pwm_clk;

  int n_asserts = 0;
  int n_fail    = 0;

  // Reference state: position in period, active period/duties, commit bookkeeping.
  int          m_pos, m_per, m_pend, m_wd, m_fs;
  int          m_duty [NCH];
  logic [3:0]  e_pwm;
  logic        e_tick, e_ack;
  int          since_commit;
  int          hi_cnt [NCH];
  int          tick_cnt, ack_cnt;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_duty(int ch, int val);
    cfg_bus.duty_in[ch*CNT_W +: CNT_W] = CNT_W'(val);
  endtask

  task automatic model_step();
    bit bnd, ld;
    int in_per, d;
    if (reset) begin
      m_pos = 0; m_per = 0; m_pend = 0; m_wd = 0; m_fs = 1;
      foreach (m_duty[i]) m_duty[i] = 0;
      e_pwm = '0; e_tick = 1'b0; e_ack = 1'b0;
      return;
    end
    bnd = (m_per == 0) || (m_pos == m_per - 1);
    ld  = bnd && (m_pend != 0 || cfg_bus.cfg_commit);
    for (int i = 0; i < NCH; i++)
      e_pwm[i] = (m_fs == 0) && (m_per != 0) && (m_pos < m_duty[i]);
    e_tick = bnd;
    e_ack  = ld;
    m_pos  = bnd ? 0 : m_pos + 1;
    if (m_wd == WD) m_fs = 1;
    m_wd   = cfg_bus.cfg_commit ? 0 : ((m_wd + 1 > WD) ? WD : m_wd + 1);
    if (cfg_bus.cfg_commit) m_pend = 1;
    if (ld) begin
      in_per = int'(cfg_bus.period_in);
      m_per  = in_per;
      for (int i = 0; i < NCH; i++) begin
        d = int'(cfg_bus.duty_in[i*CNT_W +: CNT_W]);
        m_duty[i] = (d > in_per) ? in_per : d;
      end
      m_pend = 0;
      m_fs   = 0;
    end
  endtask

  // One clock: advance the model with the inputs present at the edge, then compare.
  task automatic cyc();
    bit was_commit;
    was_commit = cfg_bus.cfg_commit;
    model_step();
    @(posedge pwm_clk);
    #1;
    since_commit = was_commit ? 0 : since_commit + 1;
    chk("pwm_out", {28'b0, pwm_out}, {28'b0, e_pwm});
    chk("period_tick", {31'b0, period_tick}, {31'b0, e_tick});
    chk("failsafe", {31'b0, failsafe}, m_fs);
    chk("update_ack", {31'b0, cfg_bus.update_ack}, {31'b0, e_ack});
    for (int i = 0; i < NCH; i++) hi_cnt[i] += int'(pwm_out[i]);
    tick_cnt += int'(period_tick);
    ack_cnt  += int'(cfg_bus.update_ack);
  endtask

  task automatic clear_counts();
    foreach (hi_cnt[i]) hi_cnt[i] = 0;
    tick_cnt = 0;
    ack_cnt  = 0;
  endtask

  task automatic run(int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  task automatic commit();
    cfg_bus.cfg_commit = 1'b1;
    cyc();
    cfg_bus.cfg_commit = 1'b0;
  endtask

  task automatic wait_pos(int p);
    for (int k = 0; k < 40 && m_pos != p; k++) cyc();
  endtask

  task automatic wait_ack(string tag);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      cyc();
      got = cfg_bus.update_ack;
    end
    chk(tag, {31'b0, got}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    bit seen;
    int at;
    since_commit = 0;
    reset = 1'b1;
    cfg_bus.cfg_commit = 1'b0;
    cfg_bus.period_in  = '0;
    cfg_bus.duty_in    = '0;
    clear_counts();

    // Reset, then no commit: motors off, tick every cycle.
    run(2);
    chk("rst_pwm", {28'b0, pwm_out}, 32'd0);
    chk("rst_failsafe", {31'b0, failsafe}, 32'd1);
    reset = 1'b0;
    clear_counts();
    run(100);
    chk("idle_ticks", tick_cnt, 100);
    chk("idle_pwm_high", hi_cnt[0] + hi_cnt[1] + hi_cnt[2] + hi_cnt[3], 0);

    // period=10, duty 3/5/0/10.
    cfg_bus.period_in = 24'd10;
    set_duty(0, 3); set_duty(1, 5); set_duty(2, 0); set_duty(3, 10);
    clear_counts();
    commit();
    chk("t2_ack_now", {31'b0, cfg_bus.update_ack}, 32'd1);
    run(2);
    clear_counts();
    run(20);
    chk("t2_ch1_high", hi_cnt[0], 6);
    chk("t2_ch2_high", hi_cnt[1], 10);
    chk("t2_ch3_high", hi_cnt[2], 0);
    chk("t2_ch4_high", hi_cnt[3], 20);
    chk("t2_ticks", tick_cnt, 2);
    chk("t2_acks", ack_cnt, 0);

    // Shadow change without commit has no effect; commit at cnt=4 lands at next wrap.
    set_duty(0, 7);
    clear_counts();
    run(10);
    chk("t3_no_commit_ch1", hi_cnt[0], 3);
    wait_pos(4);
    commit();
    chk("t3_no_early_ack", {31'b0, cfg_bus.update_ack}, 32'd0);
    wait_ack("t3_ack");
    clear_counts();
    run(10);
    chk("t3_new_ch1", hi_cnt[0], 7);

    // Clamp and commit on the exact wrap cycle.
    set_duty(1, 20);
    wait_pos(9);
    commit();
    chk("t4_same_cycle_ack", {31'b0, cfg_bus.update_ack}, 32'd1);
    clear_counts();
    run(10);
    chk("t4_ch2_clamped", hi_cnt[1], 10);

    // Watchdog expiry and recovery.
    seen = 1'b0;
    at   = -1;
    for (int k = 0; k < 120 && !seen; k++) begin
      cyc();
      if (failsafe === 1'b1) begin
        seen = 1'b1;
        at   = since_commit;
      end
    end
    chk("t5_wdog_cycle", at, 51);
    cyc();
    chk("t5_pwm_forced", {28'b0, pwm_out}, 32'd0);
    commit();
    wait_ack("t5_recover_ack");
    chk("t5_failsafe_clear", {31'b0, failsafe}, 32'd0);
    clear_counts();
    run(10);
    chk("t5_ch1_resumed", hi_cnt[0], 7);

    // Reset mid-period with a pending commit: commit is lost.
    wait_pos(3);
    commit();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("t6_pwm", {28'b0, pwm_out}, 32'd0);
    chk("t6_failsafe", {31'b0, failsafe}, 32'd1);
    chk("t6_ack", {31'b0, cfg_bus.update_ack}, 32'd0);
    clear_counts();
    run(20);
    chk("t6_pending_lost", ack_cnt, 0);

    // Randomized traffic against the model.
    for (int k = 0; k < 500; k++) begin
      if ($urandom_range(0, 11) == 0) cfg_bus.period_in = CNT_W'($urandom_range(0, 16));
      if ($urandom_range(0, 5) == 0)  set_duty(int'($urandom_range(0, NCH-1)), int'($urandom_range(0, 20)));
      cfg_bus.cfg_commit = ($urandom_range(0, 9) == 0);
      reset = ($urandom_range(0, 249) == 0);
      cyc();
    end
    cfg_bus.cfg_commit = 1'b0;
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
